// File: rtl/axil_sram_slave.sv
// AXI4-Lite slave backed by an internal DEPTH x DATA_W array, with SLVERR on
// out-of-range addresses and an optional extra response delay per channel.
module axil_sram_slave #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH       = 1024,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                DELAY_MODE  = 2,
  parameter int                FIXED_DELAY = 3,
  parameter int                LFSR_W      = 5,
  parameter logic [LFSR_W-1:0] RD_POLY     = 5'h12,
  parameter logic [LFSR_W-1:0] WR_POLY     = 5'h10,
  parameter logic [LFSR_W-1:0] LFSR_SEED   = 5'h01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);
  // state  | meaning
  // R_IDLE | ready for AR       W_IDLE | collecting AW and W into holds
  // R_WAIT | counting delay     W_WAIT | counting delay after commit
  // R_RESP | rvalid until rready W_RESP | bvalid until bready
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = (LFSR_W > 8) ? LFSR_W : 8;
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * STRB_W);

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  // Offset is taken one bit wider so addresses below BASE_ADDR wrap to huge values.
  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} - {1'b0, BASE_ADDR}) < SPAN;
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_ADDR) >> OFF_W);
  endfunction

  function automatic logic [CNT_W-1:0] pick_delay(input logic [LFSR_W-1:0] q);
    case (DELAY_MODE)
      0:       return '0;
      1:       return CNT_W'(FIXED_DELAY);
      default: return CNT_W'(q);
    endcase
  endfunction

  logic [LFSR_W-1:0] rd_lfsr, wr_lfsr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_lfsr <= LFSR_SEED;
      wr_lfsr <= LFSR_SEED;
    end else begin
      rd_lfsr <= (rd_lfsr >> 1) ^ (rd_lfsr[0] ? RD_POLY : '0);
      wr_lfsr <= (wr_lfsr >> 1) ^ (wr_lfsr[0] ? WR_POLY : '0);
    end
  end

  r_state_t         r_state, r_next;
  logic [IDX_W-1:0] r_idx, rs_idx;
  logic             r_ok, rs_ok, ar_fire;
  logic [CNT_W-1:0] r_cnt, rd_d;

  assign rd_d    = pick_delay(rd_lfsr);
  assign ar_fire = arvalid && arready;
  // A zero-delay read samples the array on the fire edge, before idx is latched.
  assign rs_idx  = (r_state == R_IDLE) ? addr_idx(araddr) : r_idx;
  assign rs_ok   = (r_state == R_IDLE) ? addr_ok(araddr)  : r_ok;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= R_IDLE;
    else      r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (arvalid) r_next = (rd_d == '0) ? R_RESP : R_WAIT;
      R_WAIT:  if (r_cnt == CNT_W'(1)) r_next = R_RESP;
      R_RESP:  if (rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = (r_state == R_IDLE);
    rvalid  = (r_state == R_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata <= '0;
      rresp <= 2'b00;
    end else begin
      if (ar_fire) begin
        r_idx <= addr_idx(araddr);
        r_ok  <= addr_ok(araddr);
        r_cnt <= rd_d;
      end else if (r_state == R_WAIT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_next == R_RESP && r_state != R_RESP) begin
        rdata <= rs_ok ? mem[rs_idx] : '0;
        rresp <= rs_ok ? 2'b00 : 2'b10;
      end
    end
  end

  w_state_t          w_state, w_next;
  logic              aw_held, w_held, aw_fire, w_fire, commit;
  logic [ADDR_W-1:0] aw_addr_q, cm_addr;
  logic [DATA_W-1:0] w_data_q, cm_data;
  logic [STRB_W-1:0] w_strb_q, cm_strb;
  logic [CNT_W-1:0]  w_cnt, wr_d;

  assign wr_d    = pick_delay(wr_lfsr);
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign commit  = rst && (w_state == W_IDLE) && (aw_held || aw_fire) && (w_held || w_fire);
  assign cm_addr = aw_held ? aw_addr_q : awaddr;
  assign cm_data = w_held  ? w_data_q  : wdata;
  assign cm_strb = w_held  ? w_strb_q  : wstrb;

  always_ff @(posedge clk) begin
    if (!rst) w_state <= W_IDLE;
    else      w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (commit) w_next = (wr_d == '0) ? W_RESP : W_WAIT;
      W_WAIT:  if (w_cnt == CNT_W'(1)) w_next = W_RESP;
      W_RESP:  if (bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = (w_state == W_IDLE) && !aw_held;
    wready  = (w_state == W_IDLE) && !w_held;
    bvalid  = (w_state == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp   <= 2'b00;
    end else if (commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp   <= addr_ok(cm_addr) ? 2'b00 : 2'b10;
      w_cnt   <= wr_d;
    end else begin
      if (aw_fire) begin
        aw_held   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (w_fire) begin
        w_held   <= 1'b1;
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (w_state == W_WAIT) w_cnt <= w_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (commit && addr_ok(cm_addr)) begin
      for (int i = 0; i < STRB_W; i++)
        if (cm_strb[i]) mem[addr_idx(cm_addr)][8*i +: 8] <= cm_data[8*i +: 8];
    end
  end
endmodule

// File: tb/tb_axil_sram_slave.sv
// Bench for axil_sram_slave: three instances (delay modes 0/1/2) checked every
// cycle against a transaction-level model, plus directed literal expectations.
module tb_axil_sram_slave;
  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [4:0]  SEED  = 5'h01;

  logic        clk = 0;
  logic        rst [3];
  logic [31:0] araddr [3], rdata [3], awaddr [3], wdata [3];
  logic        arvalid [3], arready [3], rvalid [3], rready [3];
  logic [1:0]  rresp [3], bresp [3];
  logic        awvalid [3], awready [3], wvalid [3], wready [3], bvalid [3], bready [3];
  logic [3:0]  wstrb [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    axil_sram_slave #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .BASE_ADDR(BASE),
                      .DELAY_MODE(g), .FIXED_DELAY(3)) u_dut (
      .clk(clk), .rst(rst[g]),
      .araddr(araddr[g]), .arvalid(arvalid[g]), .arready(arready[g]),
      .rdata(rdata[g]), .rresp(rresp[g]), .rvalid(rvalid[g]), .rready(rready[g]),
      .awaddr(awaddr[g]), .awvalid(awvalid[g]), .awready(awready[g]),
      .wdata(wdata[g]), .wstrb(wstrb[g]), .wvalid(wvalid[g]), .wready(wready[g]),
      .bresp(bresp[g]), .bvalid(bvalid[g]), .bready(bready[g]));
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input int i, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %0h, expected %0h", nm, i, act, exp);
    end
  endtask

  task automatic timeout(input string nm, input int i);
    n_tests++;
    n_fail++;
    $display("FAIL timeout_%s inst%0d: got no handshake, expected one within budget", nm, i);
  endtask

  function automatic logic [4:0] lfsr_step(input logic [4:0] q, input logic [4:0] poly);
    return q[0] ? ((q >> 1) ^ poly) : (q >> 1);
  endfunction

  function automatic bit in_rng(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(DEPTH * 4));
  endfunction

  function automatic int ridx(input logic [31:0] a);
    return int'((a - BASE) >> 2) % DEPTH;
  endfunction

  function automatic int dly(input int i, input logic [4:0] q);
    return (i == 0) ? 0 : (i == 1) ? 3 : int'(q);
  endfunction

  // Transaction-level model: each accepted request records the edge at which
  // its response becomes visible; data is taken from a shadow array.
  int          e = 0;
  logic        m_r_out [3], m_r_known [3], m_w_out [3], m_aw_h [3], m_w_h [3];
  int          m_r_due [3], m_w_due [3];
  logic [31:0] m_r_addr [3], m_r_data [3], m_aw_a [3], m_w_d [3];
  logic [1:0]  m_r_resp [3], m_b_resp [3];
  logic [3:0]  m_w_s [3];
  logic [4:0]  m_rl [3], m_wl [3];
  logic [31:0] mmem [3][DEPTH];
  logic        mknown [3][DEPTH];

  initial begin
    for (int i = 0; i < 3; i++) begin
      m_r_out[i] = 0; m_w_out[i] = 0; m_aw_h[i] = 0; m_w_h[i] = 0;
      for (int j = 0; j < DEPTH; j++) mknown[i][j] = 0;
    end
  end

  task automatic model_edge(input int i);
    logic ar_f, aw_a, w_a;
    int rd, wd, idx;
    if (!rst[i]) begin
      m_r_out[i] = 0; m_w_out[i] = 0; m_aw_h[i] = 0; m_w_h[i] = 0;
      m_rl[i] = SEED; m_wl[i] = SEED;
    end else begin
      rd = dly(i, m_rl[i]);
      wd = dly(i, m_wl[i]);
      m_rl[i] = lfsr_step(m_rl[i], 5'h12);
      m_wl[i] = lfsr_step(m_wl[i], 5'h10);
      ar_f = !m_r_out[i] && arvalid[i];
      if (m_r_out[i] && e > m_r_due[i] && rready[i]) m_r_out[i] = 0;
      if (ar_f) begin
        m_r_out[i] = 1; m_r_due[i] = e + rd; m_r_addr[i] = araddr[i];
      end
      if (m_r_out[i] && m_r_due[i] == e) begin
        if (in_rng(m_r_addr[i])) begin
          idx = ridx(m_r_addr[i]);
          m_r_data[i] = mmem[i][idx]; m_r_known[i] = mknown[i][idx]; m_r_resp[i] = 2'b00;
        end else begin
          m_r_data[i] = 0; m_r_known[i] = 1; m_r_resp[i] = 2'b10;
        end
      end
      if (m_w_out[i] && e > m_w_due[i] && bready[i]) m_w_out[i] = 0;
      else if (!m_w_out[i]) begin
        aw_a = m_aw_h[i] || awvalid[i];
        w_a  = m_w_h[i] || wvalid[i];
        if (!m_aw_h[i] && awvalid[i]) m_aw_a[i] = awaddr[i];
        if (!m_w_h[i] && wvalid[i]) begin m_w_d[i] = wdata[i]; m_w_s[i] = wstrb[i]; end
        if (aw_a && w_a) begin
          if (in_rng(m_aw_a[i])) begin
            idx = ridx(m_aw_a[i]);
            for (int b = 0; b < 4; b++)
              if (m_w_s[i][b]) mmem[i][idx][8*b +: 8] = m_w_d[i][8*b +: 8];
            if (m_w_s[i] == 4'hF) mknown[i][idx] = 1;
          end
          m_b_resp[i] = in_rng(m_aw_a[i]) ? 2'b00 : 2'b10;
          m_aw_h[i] = 0; m_w_h[i] = 0; m_w_out[i] = 1; m_w_due[i] = e + wd;
        end else begin
          m_aw_h[i] = aw_a; m_w_h[i] = w_a;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    e++;
    for (int i = 0; i < 3; i++) model_edge(i);
  end

  always @(negedge clk) begin
    if (e > 0) begin
      for (int i = 0; i < 3; i++) begin
        check("arready", i, arready[i], !m_r_out[i]);
        check("rvalid", i, rvalid[i], m_r_out[i] && e >= m_r_due[i]);
        if (m_r_out[i] && e >= m_r_due[i]) begin
          check("rresp", i, rresp[i], m_r_resp[i]);
          if (m_r_known[i]) check("rdata", i, rdata[i], m_r_data[i]);
        end
        check("awready", i, awready[i], !m_w_out[i] && !m_aw_h[i]);
        check("wready", i, wready[i], !m_w_out[i] && !m_w_h[i]);
        check("bvalid", i, bvalid[i], m_w_out[i] && e >= m_w_due[i]);
        if (m_w_out[i] && e >= m_w_due[i]) check("bresp", i, bresp[i], m_b_resp[i]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int i, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int w_lead, output logic [1:0] resp);
    bit done, af, wf, bh;
    done = 0; resp = 2'b11;
    awaddr[i] = a; wdata[i] = d; wstrb[i] = s; wvalid[i] = 1; awvalid[i] = (w_lead == 0);
    for (int k = 1; k <= 200 && !done; k++) begin
      @(negedge clk);
      af = awvalid[i] && awready[i];
      wf = wvalid[i] && wready[i];
      bh = bvalid[i] && bready[i];
      if (bh) resp = bresp[i];
      tick();
      if (af) awvalid[i] = 0;
      if (wf) wvalid[i] = 0;
      if (w_lead > 0 && k == w_lead) awvalid[i] = 1;
      done = bh;
    end
    if (!done) timeout("write", i);
    awvalid[i] = 0; wvalid[i] = 0;
  endtask

  task automatic do_read(input int i, input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit done, af;
    done = 0; d = 32'hxxxx_xxxx; resp = 2'b11;
    araddr[i] = a; arvalid[i] = 1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      af = arvalid[i] && arready[i];
      if (rvalid[i] && rready[i]) begin d = rdata[i]; resp = rresp[i]; done = 1; end
      tick();
      if (af) arvalid[i] = 0;
    end
    if (!done) timeout("read", i);
    arvalid[i] = 0;
  endtask

  function automatic logic [31:0] rand_addr();
    if ($urandom_range(0, 7) == 0)
      return ($urandom_range(0, 1) == 1) ? BASE + 32'(DEPTH * 4) + $urandom_range(0, 255)
                                         : BASE - 32'd1 - $urandom_range(0, 255);
    return BASE + $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
  endfunction

  initial begin
    #500_000;
    $display("FAIL watchdog inst0: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d, d2;
    logic [1:0]  r, r2;
    bit rd_done, wr_done, af, awf, wf;
    int n_done, cyc;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 0; arvalid[i] = 0; awvalid[i] = 0; wvalid[i] = 0;
      rready[i] = 1; bready[i] = 1; araddr[i] = 0; awaddr[i] = 0; wdata[i] = 0; wstrb[i] = 0;
    end

    check("pin_lfsr_rd1", 0, lfsr_step(5'h01, 5'h12), 5'h12);
    check("pin_lfsr_rd2", 0, lfsr_step(5'h12, 5'h12), 5'h09);
    check("pin_lfsr_rd3", 0, lfsr_step(5'h09, 5'h12), 5'h16);
    check("pin_lfsr_wr1", 0, lfsr_step(5'h01, 5'h10), 5'h10);
    check("pin_range_hi", 0, in_rng(BASE + 32'(DEPTH * 4)), 0);
    check("pin_range_lo", 0, in_rng(BASE - 32'd4), 0);
    check("pin_range_last", 0, in_rng(BASE + 32'(DEPTH * 4) - 32'd1), 1);

    repeat (3) tick();
    @(negedge clk);
    check("rst_rvalid", 0, rvalid[0], 0);
    check("rst_bvalid", 0, bvalid[0], 0);
    check("rst_rdata", 0, rdata[0], 0);
    check("rst_rresp", 0, rresp[0], 0);
    check("rst_bresp", 0, bresp[0], 0);
    check("rst_arready", 0, arready[0], 1);
    check("rst_awready", 0, awready[0], 1);
    check("rst_wready", 0, wready[0], 1);
    tick();
    for (int i = 0; i < 3; i++) rst[i] = 1;
    tick();

    // mode 0: basic write/read, W-before-AW merge, partial strobe
    do_write(0, BASE, 32'hDEAD_BEEF, 4'hF, 0, r);
    check("wr_base_bresp", 0, r, 2'b00);
    do_read(0, BASE, d, r);
    check("rd_base_data", 0, d, 32'hDEAD_BEEF);
    check("rd_base_resp", 0, r, 2'b00);
    do_write(0, BASE + 4, 32'h1122_3344, 4'hF, 0, r);
    do_write(0, BASE + 4, 32'h0000_AB00, 4'b0010, 3, r);
    check("wlead_bresp", 0, r, 2'b00);
    do_read(0, BASE + 4, d, r);
    check("strb_merge_data", 0, d, 32'h1122_AB44);

    // out of range: SLVERR, zero data, array untouched
    do_write(0, BASE + 32'(4 * (DEPTH - 1)), 32'h5555_AAAA, 4'hF, 0, r);
    do_read(0, BASE + 32'(DEPTH * 4), d, r);
    check("oor_hi_data", 0, d, 0);
    check("oor_hi_resp", 0, r, 2'b10);
    do_read(0, BASE - 32'd4, d, r);
    check("oor_lo_data", 0, d, 0);
    check("oor_lo_resp", 0, r, 2'b10);
    do_write(0, BASE + 32'(DEPTH * 4), 32'hFFFF_FFFF, 4'hF, 0, r);
    check("oor_hi_bresp", 0, r, 2'b10);
    do_write(0, BASE - 32'd4, 32'hFFFF_FFFF, 4'hF, 0, r);
    check("oor_lo_bresp", 0, r, 2'b10);
    do_write(0, BASE, 32'h0, 4'h0, 0, r);
    check("strb0_bresp", 0, r, 2'b00);
    do_read(0, BASE, d, r);
    check("oor_keep_word0", 0, d, 32'hDEAD_BEEF);
    do_read(0, BASE + 32'(4 * (DEPTH - 1)), d, r);
    check("oor_keep_last", 0, d, 32'h5555_AAAA);

    // same-cycle read sample and write commit to one word
    do_write(0, BASE + 8, 32'hCAFE_F00D, 4'hF, 0, r);
    araddr[0] = BASE + 8; awaddr[0] = BASE + 8; wdata[0] = 32'h0BAD_C0DE; wstrb[0] = 4'hF;
    arvalid[0] = 1; awvalid[0] = 1; wvalid[0] = 1;
    rd_done = 0; wr_done = 0; d = 0;
    for (int k = 0; k < 100 && !(rd_done && wr_done); k++) begin
      @(negedge clk);
      af = arvalid[0] && arready[0]; awf = awvalid[0] && awready[0]; wf = wvalid[0] && wready[0];
      if (rvalid[0] && rready[0] && !rd_done) begin d = rdata[0]; rd_done = 1; end
      if (bvalid[0] && bready[0]) wr_done = 1;
      tick();
      if (af) arvalid[0] = 0;
      if (awf) awvalid[0] = 0;
      if (wf) wvalid[0] = 0;
    end
    if (!(rd_done && wr_done)) timeout("same_cycle", 0);
    arvalid[0] = 0; awvalid[0] = 0; wvalid[0] = 0;
    check("same_cycle_old", 0, d, 32'hCAFE_F00D);
    do_read(0, BASE + 8, d, r);
    check("same_cycle_new", 0, d, 32'h0BAD_C0DE);

    // mode 1: normal transfer, then reset while the read is waiting
    do_write(1, BASE + 12, 32'h0102_0304, 4'hF, 0, r);
    do_read(1, BASE + 12, d, r);
    check("m1_rd_data", 1, d, 32'h0102_0304);
    araddr[1] = BASE + 12; arvalid[1] = 1;
    @(negedge clk);
    check("m1_pre_arready", 1, arready[1], 1);
    tick();
    arvalid[1] = 0;
    tick();
    tick();
    rst[1] = 0;
    tick();
    rst[1] = 1;
    @(negedge clk);
    check("m1_rst_rvalid", 1, rvalid[1], 0);
    check("m1_rst_arready", 1, arready[1], 1);
    tick();
    do_read(1, BASE + 12, d, r);
    check("m1_after_rst_data", 1, d, 32'h0102_0304);
    check("m1_after_rst_resp", 1, r, 2'b00);

    // mode 2: random back-to-back reads with random rready stalls
    for (int j = 0; j < 16; j++) do_write(2, BASE + 32'(j * 4), $urandom, 4'hF, 0, r);
    do_write(2, BASE + 20, 32'h7777_1234, 4'hF, 0, r);
    do_read(2, BASE + 20, d2, r2);
    check("m2_rd_data", 2, d2, 32'h7777_1234);
    n_done = 0; cyc = 0;
    araddr[2] = rand_addr(); arvalid[2] = 1;
    while (n_done < 200 && cyc < 20000) begin
      @(negedge clk);
      af = arvalid[2] && arready[2];
      rd_done = rvalid[2] && rready[2];
      tick();
      cyc++;
      if (rd_done) n_done++;
      if (af) araddr[2] = rand_addr();
      rready[2] = ($urandom_range(0, 1) == 1);
    end
    check("m2_reads_done", 2, n_done, 200);
    arvalid[2] = 0; rready[2] = 1;
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
